// File: rtl/fifo_pkg.sv
// Pointer helpers shared by the write- and read-side FIFO controllers.
// Conversions work on a fixed 32-bit container; callers zero-extend and keep the low bits.
package fifo_pkg;

  localparam int PT_DEFAULT    = 3;
  localparam int PTR_W_DEFAULT = PT_DEFAULT + 1;
  localparam int CONV_W        = 32;

  function automatic int ptr_width(input int pt);
    return pt + 1;
  endfunction

  function automatic logic [CONV_W-1:0] bin2gray(input logic [CONV_W-1:0] b);
    return (b >> 1) ^ b;
  endfunction

  // Leading zeros from zero-extension do not disturb the prefix XOR.
  function automatic logic [CONV_W-1:0] gray2bin(input logic [CONV_W-1:0] g);
    logic [CONV_W-1:0] b;
    b[CONV_W-1] = g[CONV_W-1];
    for (int i = CONV_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for Gray-coded pointers crossing clock domains.
// Only one bit changes per source update, so a multi-bit capture stays coherent.
module sync_2ff #(
  parameter int WIDTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/fifo_write_ctrl.sv
// Write-side control of the asynchronous FIFO: pointers, memory strobe, and
// full/almost-full/level flags derived from the synchronized read pointer.
module fifo_write_ctrl
  import fifo_pkg::*;
#(
  parameter int pt    = 3,
  parameter int af_th = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [pt:0]   g_rdpt,
  input  logic          ovf_clr,
  output logic          wen_mem,
  output logic [pt-1:0] waddr,
  output logic [pt:0]   b_wrpt,
  output logic [pt:0]   g_wrpt,
  output logic          full,
  output logic          almost_full,
  output logic [pt:0]   wlevel,
  output logic          overflow
);

  localparam int            PW     = ptr_width(pt);
  localparam logic [PW-1:0] AF_LIM = PW'((1 << pt) - af_th);

  logic [PW-1:0]     r_b_wrpt;
  logic [PW-1:0]     r_g_wrpt;
  logic              r_full;
  logic              r_afull;
  logic [PW-1:0]     r_level;
  logic              r_ovf;

  logic [PW-1:0]     w_g_rdpt_sync;
  logic [CONV_W-1:0] w_rd_bin_full;
  logic [CONV_W-1:PW] w_unused_rd_bin_hi;
  logic [PW-1:0]     w_b_rdpt_sync;
  logic              w_accept;
  logic [PW-1:0]     w_next_b;
  logic [PW-1:0]     w_next_g;
  logic [PW-1:0]     w_full_match;
  logic              w_nxt_full;
  logic [PW-1:0]     w_nxt_level;
  logic              w_nxt_afull;

  sync_2ff #(.WIDTH(PW)) u_rdpt_sync (
    .i_clk (clk),
    .i_rst (rst),
    .i_d   (g_rdpt),
    .o_q   (w_g_rdpt_sync)
  );

  assign w_rd_bin_full      = gray2bin(CONV_W'(w_g_rdpt_sync));
  assign w_b_rdpt_sync      = w_rd_bin_full[PW-1:0];
  assign w_unused_rd_bin_hi = w_rd_bin_full[CONV_W-1:PW];

  assign w_accept = we & ~r_full;
  assign w_next_b = r_b_wrpt + {{(PW-1){1'b0}}, w_accept};
  assign w_next_g = (w_next_b >> 1) ^ w_next_b;

  // Full when the writer is exactly one lap ahead: in Gray code that is the
  // read pointer with its top two bits inverted.
  assign w_full_match = {~w_g_rdpt_sync[pt:pt-1], w_g_rdpt_sync[pt-2:0]};
  assign w_nxt_full   = (w_next_g == w_full_match);
  assign w_nxt_level  = w_next_b - w_b_rdpt_sync;
  assign w_nxt_afull  = (w_nxt_level >= AF_LIM);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_b_wrpt <= '0;
      r_g_wrpt <= '0;
      r_full   <= 1'b0;
      r_afull  <= 1'b0;
      r_level  <= '0;
    end else begin
      r_b_wrpt <= w_next_b;
      r_g_wrpt <= w_next_g;
      r_full   <= w_nxt_full;
      r_afull  <= w_nxt_afull;
      r_level  <= w_nxt_level;
    end
  end

  // A fresh overflow outranks a clear arriving in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ovf <= 1'b0;
    end else if (we & r_full) begin
      r_ovf <= 1'b1;
    end else if (ovf_clr) begin
      r_ovf <= 1'b0;
    end
  end

  assign wen_mem     = w_accept;
  assign waddr       = r_b_wrpt[pt-1:0];
  assign b_wrpt      = r_b_wrpt;
  assign g_wrpt      = r_g_wrpt;
  assign full        = r_full;
  assign almost_full = r_afull;
  assign wlevel      = r_level;
  assign overflow    = r_ovf;

endmodule

// File: tb/tb_fifo_write_ctrl.sv
// Directed bench for fifo_write_ctrl (pt=3, af_th=2): vector table for fill,
// overflow and drain, plus hand sequences for reset, wrap and mid-run reset.
module tb_fifo_write_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       we = 1'b1;
  logic [3:0] g_rdpt = 4'h0;
  logic       ovf_clr = 1'b0;
  logic       wen_mem;
  logic [2:0] waddr;
  logic [3:0] b_wrpt;
  logic [3:0] g_wrpt;
  logic       full;
  logic       almost_full;
  logic [3:0] wlevel;
  logic       overflow;

  int n_tests = 0;
  int n_fail  = 0;

  fifo_write_ctrl #(.pt(3), .af_th(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .we          (we),
    .g_rdpt      (g_rdpt),
    .ovf_clr     (ovf_clr),
    .wen_mem     (wen_mem),
    .waddr       (waddr),
    .b_wrpt      (b_wrpt),
    .g_wrpt      (g_wrpt),
    .full        (full),
    .almost_full (almost_full),
    .wlevel      (wlevel),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       we;
    logic [3:0] g_rd;
    logic       clr;
    logic       exp_wen;
    logic [2:0] exp_waddr;
    logic [3:0] exp_b;
    logic [3:0] exp_g;
    logic       exp_full;
    logic       exp_af;
    logic [3:0] exp_lvl;
    logic       exp_ovf;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] gray4(input logic [3:0] b);
    return (b >> 1) ^ b;
  endfunction

  task automatic add(input logic i_we, input logic [3:0] i_grd, input logic i_clr,
                     input logic e_wen, input logic [2:0] e_wa, input logic [3:0] e_b,
                     input logic [3:0] e_g, input logic e_full, input logic e_af,
                     input logic [3:0] e_lvl, input logic e_ovf);
    vec_t v;
    v.we = i_we; v.g_rd = i_grd; v.clr = i_clr;
    v.exp_wen = e_wen; v.exp_waddr = e_wa; v.exp_b = e_b; v.exp_g = e_g;
    v.exp_full = e_full; v.exp_af = e_af; v.exp_lvl = e_lvl; v.exp_ovf = e_ovf;
    vecs.push_back(v);
  endtask

  task automatic chk_zero_regs(input string tag);
    chk({tag, " b_wrpt"},      32'(b_wrpt), 0);
    chk({tag, " g_wrpt"},      32'(g_wrpt), 0);
    chk({tag, " wlevel"},      32'(wlevel), 0);
    chk({tag, " full"},        32'(full), 0);
    chk({tag, " almost_full"}, 32'(almost_full), 0);
    chk({tag, " overflow"},    32'(overflow), 0);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1; we = 1'b0; ovf_clr = 1'b0; g_rdpt = 4'h0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    //        we grd clr | wen wa  b   g   full af lvl ovf
    add(1, 4'h0, 0,   1, 3'd0, 4'd1, 4'h1, 0, 0, 4'd1, 0);
    add(1, 4'h0, 0,   1, 3'd1, 4'd2, 4'h3, 0, 0, 4'd2, 0);
    add(1, 4'h0, 0,   1, 3'd2, 4'd3, 4'h2, 0, 0, 4'd3, 0);
    add(1, 4'h0, 0,   1, 3'd3, 4'd4, 4'h6, 0, 0, 4'd4, 0);
    add(1, 4'h0, 0,   1, 3'd4, 4'd5, 4'h7, 0, 0, 4'd5, 0);
    add(1, 4'h0, 0,   1, 3'd5, 4'd6, 4'h5, 0, 1, 4'd6, 0);
    add(1, 4'h0, 0,   1, 3'd6, 4'd7, 4'h4, 0, 1, 4'd7, 0);
    add(1, 4'h0, 0,   1, 3'd7, 4'd8, 4'hC, 1, 1, 4'd8, 0);
    add(1, 4'h0, 0,   0, 3'd0, 4'd8, 4'hC, 1, 1, 4'd8, 1);
    add(1, 4'h0, 1,   0, 3'd0, 4'd8, 4'hC, 1, 1, 4'd8, 1);
    add(0, 4'h0, 1,   0, 3'd0, 4'd8, 4'hC, 1, 1, 4'd8, 0);
    add(0, 4'h1, 0,   0, 3'd0, 4'd8, 4'hC, 1, 1, 4'd8, 0);
    add(0, 4'h1, 0,   0, 3'd0, 4'd8, 4'hC, 1, 1, 4'd8, 0);
    add(0, 4'h1, 0,   0, 3'd0, 4'd8, 4'hC, 0, 1, 4'd7, 0);
    add(1, 4'h1, 0,   1, 3'd0, 4'd9, 4'hD, 1, 1, 4'd8, 0);
    add(1, 4'h1, 0,   0, 3'd1, 4'd9, 4'hD, 1, 1, 4'd8, 1);

    // Reset held 3 cycles with a pending write request.
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      #1;
      chk("reset wen_mem", 32'(wen_mem), 1);
      chk("reset waddr", 32'(waddr), 0);
      chk_zero_regs("reset");
    end
    @(negedge clk);
    rst = 1'b0; we = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      we = vecs[i].we; g_rdpt = vecs[i].g_rd; ovf_clr = vecs[i].clr;
      #1;
      chk($sformatf("vec%0d wen_mem", i), 32'(wen_mem), 32'(vecs[i].exp_wen));
      chk($sformatf("vec%0d waddr", i),   32'(waddr),   32'(vecs[i].exp_waddr));
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d b_wrpt", i),      32'(b_wrpt),      32'(vecs[i].exp_b));
      chk($sformatf("vec%0d g_wrpt", i),      32'(g_wrpt),      32'(vecs[i].exp_g));
      chk($sformatf("vec%0d full", i),        32'(full),        32'(vecs[i].exp_full));
      chk($sformatf("vec%0d almost_full", i), 32'(almost_full), 32'(vecs[i].exp_af));
      chk($sformatf("vec%0d wlevel", i),      32'(wlevel),      32'(vecs[i].exp_lvl));
      chk($sformatf("vec%0d overflow", i),    32'(overflow),    32'(vecs[i].exp_ovf));
    end

    // Wrap: reader follows the writer immediately; sync delay leaves a level of 3.
    pulse_reset();
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      we = 1'b1; g_rdpt = gray4(n[3:0]); ovf_clr = 1'b0;
      #1;
      chk($sformatf("wrap%0d waddr", n), 32'(waddr), 32'(n[2:0]));
      @(posedge clk);
      #1;
      chk($sformatf("wrap%0d g_wrpt", n), 32'(g_wrpt), 32'(gray4(4'(n + 1))));
      chk($sformatf("wrap%0d full", n),   32'(full), 0);
      chk($sformatf("wrap%0d wlevel", n), 32'(wlevel), (n < 2) ? n + 1 : 3);
    end

    // Mid-operation reset at level 5.
    pulse_reset();
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      we = 1'b1;
    end
    @(negedge clk);
    we = 1'b0;
    #1;
    chk("mid wlevel before reset", 32'(wlevel), 5);
    #1;
    rst = 1'b1;
    #1;
    chk_zero_regs("mid async");
    @(negedge clk);
    rst = 1'b0; we = 1'b1;
    #1;
    chk("post reset wen_mem", 32'(wen_mem), 1);
    chk("post reset waddr", 32'(waddr), 0);
    @(posedge clk);
    #1;
    chk("post reset b_wrpt", 32'(b_wrpt), 1);
    chk("post reset wlevel", 32'(wlevel), 1);
    @(negedge clk);
    we = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_write_ctrl.md
# fifo_write_ctrl

Write-domain control for the N-bit asynchronous FIFO. It owns the binary and Gray write pointers, the memory write enable and address, and the full, almost-full and fill-level flags. It brings the read-domain Gray pointer into the write clock through an internal 2-flop synchronizer. The exported Gray write pointer is synchronized by the read side, which compares it against its own read pointer to generate `empty`.

## Interface
- `pt`, default 3: address width. FIFO depth is 2^pt, pointer width is pt+1. Minimum legal value is 2.
- `af_th`, default 2: `almost_full` is high while the free-slot count is at most `af_th`. Legal range is 0 to 2^pt − 1.
- `clk` in, 1: write-domain clock. This is the block's only clock.
- `rst` in, 1: asynchronous, active-high reset.
- `we` in, 1: write request from the producer.
- `g_rdpt` in, pt+1: Gray read pointer, driven from the read clock domain.
- `ovf_clr` in, 1: synchronous clear for `overflow`.
- `wen_mem` out, 1: memory write strobe, combinational, equal to `we & !full`.
- `waddr` out, pt: memory write address, equal to `b_wrpt[pt-1:0]`.
- `b_wrpt` out, pt+1: binary write pointer, registered.
- `g_wrpt` out, pt+1: Gray write pointer, registered. It is sent to the read domain.
- `full` out, 1: registered.
- `almost_full` out, 1: registered.
- `wlevel` out, pt+1: registered occupancy as seen from the write side, range 0 to 2^pt.
- `overflow` out, 1: sticky error flag, set when a write is attempted while full.

## Operation
- Write acceptance: a write is accepted when `we & !full`. When accepted:
  - `next_b_wrpt = b_wrpt + 1`, with natural modulo-2^(pt+1) wrap.
  - `next_g_wrpt = (next_b_wrpt >> 1) ^ next_b_wrpt`.
- Read pointer synchronization:
  - `g_rdpt` passes through two flops to produce `g_rdpt_sync`.
  - `g_rdpt_sync` is converted from Gray to binary to give `b_rdpt_sync`.
- Next-cycle flags:
  - `nxt_full = (next_g_wrpt == {~g_rdpt_sync[pt:pt-1], g_rdpt_sync[pt-2:0]})`.
  - `nxt_level = next_b_wrpt − b_rdpt_sync`, computed mod 2^(pt+1).
  - `nxt_afull = (nxt_level >= 2^pt − af_th)`.
- Registering: `full`, `almost_full` and `wlevel` all register the `nxt_*` values every cycle, whether or not a write occurs.
- Blocked writes: a write attempted while `full` is dropped.
  - Pointers hold.
  - `wen_mem` stays 0.
  - `overflow` is set on the next edge.
- Overflow clear: `overflow` clears on `ovf_clr`. If `ovf_clr` and a new overflow occur in the same cycle, set wins.
- Pessimism: flags are conservative. Read-side activity reaches the write domain late, so the FIFO can look fuller than it is, but never emptier.

## Timing
- Reset values, all asynchronous and forced while `rst` is high:
  - `b_wrpt`, `g_wrpt`, `wlevel`: 0.
  - `full`, `almost_full`, `overflow`: 0.
  - Synchronizer flops: 0.
- Write path latency:
  - `wen_mem` and `waddr` reflect the current cycle with zero latency.
  - Pointers advance on the edge that accepts the write.
  - `full` rises on that same edge when the accepted write fills the last slot. No extra write can be accepted after the FIFO fills.
- Read pointer latency: a change on `g_rdpt` reaches `g_rdpt_sync` after 2 `clk` edges. It affects `full`, `almost_full` and `wlevel` on the 3rd edge.
- Simultaneous write and read-pointer advance while full:
  - The write is still blocked in that cycle.
  - `full` drops once the synchronized pointer arrives.
- Wrap-around: the pointer MSB toggles every 2^pt accepted writes. `full` detection depends on the MSB and MSB−1 inversion, and must hold across any number of wraps.
- Reset mid-operation: all state returns to reset values immediately. The first accepted write after reset goes to `waddr` 0.

## Structure
- Shared package `fifo_pkg` holds:
  - a `gray2bin` function and a `bin2gray` function,
  - the pointer-width constant `pt+1`.
  These are shared with the read side.
- Sub-module `sync_2ff`, parameter width pt+1, built from 2 flops with the same asynchronous active-high reset. It is reused for the read side's write-pointer sync.
- Everything else lives flat in `fifo_write_ctrl`.

## Test plan
- Reset: hold `rst` for 3 cycles with `we` = 1. Expect all outputs 0, `wen_mem` = 1 while `full` = 0, and pointers held at 0 throughout reset.
- Fill (pt = 3, `g_rdpt` = 0): issue 8 consecutive writes.
  - `waddr` steps 0 through 7.
  - `wlevel` reads 1 through 8.
  - `almost_full` rises after the 6th write.
  - `full` rises after the 8th write, with `g_wrpt` = 4'b1100.
- Overflow: from full, hold `we` for 2 cycles.
  - `wen_mem` = 0 and `b_wrpt` holds at 8.
  - `overflow` goes to 1 and stays there.
  - Pulse `ovf_clr`: `overflow` returns to 0.
- Read drain: while full, step `g_rdpt` to 4'b0001.
  - `full` drops on the 3rd edge and `wlevel` = 7.
  - The next write is accepted at `waddr` 0.
- Wrap: run 40 writes with `g_rdpt` tracking at a lag of 3. Expect no false `full`, correct `g_wrpt` Gray sequence across the MSB toggles, and `wlevel` = 3 at steady state.
- Mid-operation reset: assert `rst` with `wlevel` = 5. Expect an immediate return to reset values, and the first write after release lands at `waddr` 0.
